// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 8-bit ALU and its command-side controller:
//   - opcode encodings (0..7)
//   - bit positions inside the 8-bit ALU flag vector
//   - controller FSM state encoding
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package alu_pkg;

    // Opcodes
    localparam logic [2:0] OP_ADD   = 3'd0;  // a + b
    localparam logic [2:0] OP_SUBAB = 3'd1;  // a - b
    localparam logic [2:0] OP_SUBBA = 3'd2;  // b - a
    localparam logic [2:0] OP_AND   = 3'd3;
    localparam logic [2:0] OP_OR    = 3'd4;
    localparam logic [2:0] OP_XOR   = 3'd5;
    localparam logic [2:0] OP_NOTA  = 3'd6;
    localparam logic [2:0] OP_CMP   = 3'd7;

    // Flag bit indices; bits 3:2 are always zero
    localparam int unsigned FLG_OVF  = 0;
    localparam int unsigned FLG_ZERO = 1;
    localparam int unsigned FLG_EQ   = 4;
    localparam int unsigned FLG_NE   = 5;
    localparam int unsigned FLG_GTA  = 6;
    localparam int unsigned FLG_GTB  = 7;

    // Controller FSM
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage : alu_pkg

// File: rtl/alu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// alu_cmd_ctrl
// Command-side master for the combinational 8-bit ALU. Accepts one
// operand/opcode command over a valid/ready handshake, presents it to the ALU
// from registers for one cycle, captures result and flags, and returns them
// over a valid/ready response channel. One command in flight at a time.
//
// Optional feature macro: ALU_CMD_CTRL_ACC_EN
//   defined   : i_cmd_use_acc=1 replaces i_cmd_a with the last captured result
//   undefined : i_cmd_use_acc is ignored and no accumulator is built
//
// Ports:
//   i_clk, i_rst_n             clock, async active-low reset
//   i_cmd_valid/o_cmd_ready    command handshake
//   i_cmd_a/b/op/use_acc       command payload
//   o_alu_a/b/op               registered ALU operands/opcode
//   i_alu_result/flag          combinational ALU outputs
//   o_rsp_valid/i_rsp_ready    response handshake
//   o_rsp_result/flag          captured ALU result and flags
//   o_ovf_cnt                  saturating count of overflowing results
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_cmd_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DW        = 8,
    parameter int unsigned OVF_CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,

    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [DW-1:0]        i_cmd_a,
    input  logic [DW-1:0]        i_cmd_b,
    input  logic [2:0]           i_cmd_op,
    input  logic                 i_cmd_use_acc,

    output logic [DW-1:0]        o_alu_a,
    output logic [DW-1:0]        o_alu_b,
    output logic [2:0]           o_alu_op,
    input  logic [DW-1:0]        i_alu_result,
    input  logic [7:0]           i_alu_flag,

    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [DW-1:0]        o_rsp_result,
    output logic [7:0]           o_rsp_flag,
    output logic [OVF_CNT_W-1:0] o_ovf_cnt
);

    state_e                 r_state;
    state_e                 w_state_nxt;

    // Held low through reset so o_cmd_ready only rises on the first clock
    // after release, not combinationally with the release itself.
    logic                   r_out_en;

    logic [DW-1:0]          r_alu_a;
    logic [DW-1:0]          r_alu_b;
    logic [2:0]             r_alu_op;
    logic [DW-1:0]          r_rsp_result;
    logic [7:0]             r_rsp_flag;
    logic [OVF_CNT_W-1:0]   r_ovf_cnt;

    logic                   w_accept;
    logic                   w_capture;
    logic [DW-1:0]          w_op_a;

    // -------------------------------------------------------------------------
    // Operand A selection
    // -------------------------------------------------------------------------
`ifdef ALU_CMD_CTRL_ACC_EN
    logic [DW-1:0] r_acc;

    assign w_op_a = i_cmd_use_acc ? r_acc : i_cmd_a;

    // Loaded for every opcode, so a compare leaves the accumulator at 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (w_capture) begin
            r_acc <= i_alu_result;
        end
    end
`else
    logic w_unused_use_acc;

    assign w_unused_use_acc = i_cmd_use_acc;
    assign w_op_a           = i_cmd_a;
`endif

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_out_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_out_en <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_cmd_ready = 1'b0;
        o_rsp_valid = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;

        unique case (r_state)
            StIdle: begin
                o_cmd_ready = r_out_en;
                w_accept    = r_out_en & i_cmd_valid;
                if (w_accept) begin
                    w_state_nxt = StExec;
                end
            end
            StExec: begin
                w_capture   = 1'b1;
                w_state_nxt = StResp;
            end
            StResp: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
        end else if (w_accept) begin
            r_alu_a  <= w_op_a;
            r_alu_b  <= i_cmd_b;
            r_alu_op <= i_cmd_op;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_result <= '0;
            r_rsp_flag   <= '0;
        end else if (w_capture) begin
            r_rsp_result <= i_alu_result;
            r_rsp_flag   <= i_alu_flag;
        end
    end

    // Saturating overflow event counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf_cnt <= '0;
        end else if (w_capture && i_alu_flag[FLG_OVF] && !(&r_ovf_cnt)) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end

    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_op     = r_alu_op;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_flag   = r_rsp_flag;
    assign o_ovf_cnt    = r_ovf_cnt;

endmodule : alu_cmd_ctrl

// File: tb/tb_alu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_ctrl
// Bench for alu_cmd_ctrl with a behavioural ALU as the sibling instance and a
// transaction-level reference model checked every cycle, plus literal
// expectations for the directed vectors.
// Honours ALU_CMD_CTRL_ACC_EN for the accumulator chain vector.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu_cmd_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_op;
    logic       cmd_use_acc;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic [7:0] alu_flag;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [7:0] rsp_flag;
    logic [7:0] ovf_cnt;

    int n_checks = 0;
    int n_errors = 0;

    alu_cmd_ctrl #(
        .DW        (8),
        .OVF_CNT_W (8)
    ) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_a       (cmd_a),
        .i_cmd_b       (cmd_b),
        .i_cmd_op      (cmd_op),
        .i_cmd_use_acc (cmd_use_acc),
        .o_alu_a       (alu_a),
        .o_alu_b       (alu_b),
        .o_alu_op      (alu_op),
        .i_alu_result  (alu_result),
        .i_alu_flag    (alu_flag),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_result  (rsp_result),
        .o_rsp_flag    (rsp_flag),
        .o_ovf_cnt     (ovf_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ALU behaviour: {result, flag}. Signed overflow for add/sub, unsigned compare.
    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
        logic [7:0] r;
        logic [7:0] f;
        r = 8'h00;
        f = 8'h00;
        case (op)
            3'd0: begin r = a + b; f[0] = (a[7] == b[7]) && (r[7] != a[7]); end
            3'd1: begin r = a - b; f[0] = (a[7] != b[7]) && (r[7] != a[7]); end
            3'd2: begin r = b - a; f[0] = (a[7] != b[7]) && (r[7] != b[7]); end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = ~a;
            default: begin
                f[4] = (a == b);
                f[5] = (a != b);
                f[6] = (a > b);
                f[7] = (a < b);
            end
        endcase
        if (op != 3'd7) f[1] = (r == 8'h00);
        return {r, f};
    endfunction

    always_comb {alu_result, alu_flag} = alu_ref(alu_a, alu_b, alu_op);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: one transaction outstanding; the response appears one
    // clock after acceptance and stays until taken.
    // -------------------------------------------------------------------------
    logic       m_live;       // first clock after reset release seen
    logic       m_busy;       // command accepted, response not yet taken
    logic       m_have_rsp;   // response visible
    logic [7:0] m_res;
    logic [7:0] m_flag;
    logic [7:0] m_acc;
    logic [7:0] m_cnt;
    logic [7:0] m_eff_a;

`ifdef ALU_CMD_CTRL_ACC_EN
    assign m_eff_a = cmd_use_acc ? m_acc : cmd_a;
`else
    assign m_eff_a = cmd_a;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_live     <= 1'b0;
            m_busy     <= 1'b0;
            m_have_rsp <= 1'b0;
            m_res      <= 8'h00;
            m_flag     <= 8'h00;
            m_acc      <= 8'h00;
            m_cnt      <= 8'h00;
        end else begin
            m_live <= 1'b1;
            if (m_live && !m_busy && cmd_valid) begin
                m_busy          <= 1'b1;
                {m_res, m_flag} <= alu_ref(m_eff_a, cmd_b, cmd_op);
            end else if (m_busy && !m_have_rsp) begin
                m_have_rsp <= 1'b1;
                m_acc      <= m_res;
                if (m_flag[0] && m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
            end else if (m_have_rsp && rsp_ready) begin
                m_busy     <= 1'b0;
                m_have_rsp <= 1'b0;
            end
        end
    end

    // Every-cycle comparison, sampled mid-cycle
    always @(negedge clk) begin
        chk("cmd_ready", cmd_ready, m_live && !m_busy);
        chk("rsp_valid", rsp_valid, m_have_rsp);
        chk("ovf_cnt",   ovf_cnt,   m_cnt);
        if (m_have_rsp) begin
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_flag",   rsp_flag,   m_flag);
        end
    end

    // -------------------------------------------------------------------------
    // Directed stimulus
    // -------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic use_acc);
        int n;
        cmd_valid   = 1'b1;
        cmd_a       = a;
        cmd_b       = b;
        cmd_op      = op;
        cmd_use_acc = use_acc;
        n = 0;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
        step();  // handshake edge
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input logic [7:0] exp_res,
                            input logic [7:0] exp_flag);
        int n;
        n = 0;
        while (!rsp_valid && n < 10) begin
            step();
            n++;
        end
        chk({name, "_latency"}, n, 1);
        chk({name, "_result"}, rsp_result, exp_res);
        chk({name, "_flag"}, rsp_flag, exp_flag);
        if (rsp_ready) step();
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_a       = 8'h00;
        cmd_b       = 8'h00;
        cmd_op      = 3'd0;
        cmd_use_acc = 1'b0;
        rsp_ready   = 1'b1;

        #1;
        chk("reset_ready", cmd_ready, 0);
        chk("reset_valid", rsp_valid, 0);
        chk("reset_alu_a", alu_a, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("ready_before_first_clk", cmd_ready, 0);
        step();
        chk("ready_after_first_clk", cmd_ready, 1);

        send(8'h7F, 8'h01, 3'd0, 1'b0);
        chk("exec_valid_low", rsp_valid, 0);
        wait_rsp("add_ovf", 8'h80, 8'h01);
        chk("ovf_cnt_one", ovf_cnt, 1);

        send(8'h05, 8'h03, 3'd7, 1'b0);
        wait_rsp("cmp_gt", 8'h00, 8'h60);
        send(8'h22, 8'h22, 3'd7, 1'b0);
        wait_rsp("cmp_eq", 8'h00, 8'h10);

        send(8'h10, 8'h10, 3'd1, 1'b0);
        wait_rsp("sub_zero", 8'h00, 8'h02);
        send(8'h10, 8'h30, 3'd2, 1'b0);
        wait_rsp("subba", 8'h20, 8'h00);

        // Accumulator chain
        send(8'h10, 8'h20, 3'd0, 1'b0);
        wait_rsp("chain_first", 8'h30, 8'h00);
        send(8'h00, 8'h05, 3'd0, 1'b1);
`ifdef ALU_CMD_CTRL_ACC_EN
        wait_rsp("chain_acc", 8'h35, 8'h00);
`else
        wait_rsp("chain_acc", 8'h05, 8'h00);
`endif

        // Backpressure with a competing command held valid throughout
        rsp_ready = 1'b0;
        send(8'h01, 8'h02, 3'd0, 1'b0);
        wait_rsp("bp_rsp", 8'h03, 8'h00);
        cmd_valid = 1'b1;
        cmd_a     = 8'h04;
        cmd_b     = 8'h04;
        cmd_op    = 3'd5;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid_held", rsp_valid, 1);
            chk("bp_result_stable", rsp_result, 8'h03);
            chk("bp_ready_low", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        step();  // response handshake
        chk("bp_idle_after_hs", cmd_ready, 1);
        chk("bp_valid_dropped", rsp_valid, 0);
        step();  // competing command accepted here
        cmd_valid = 1'b0;
        chk("bp_second_exec", rsp_valid, 0);
        wait_rsp("bp_second", 8'h00, 8'h02);

        // Reset while in EXEC
        send(8'h7F, 8'h7F, 3'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_exec_valid", rsp_valid, 0);
        chk("rst_exec_ready", cmd_ready, 0);
        chk("rst_exec_alu_a", alu_a, 0);
        chk("rst_exec_cnt", ovf_cnt, 0);
        chk("rst_exec_result", rsp_result, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_no_rsp", rsp_valid, 0);
        end
        send(8'hF0, 8'h3C, 3'd3, 1'b0);
        wait_rsp("after_reset", 8'h30, 8'h00);
        chk("cnt_after_reset", ovf_cnt, 0);

        // Counter saturation
        for (int i = 0; i < 256; i++) begin
            send(8'h7F, 8'h01, 3'd0, 1'b0);
            wait_rsp("sat_loop", 8'h80, 8'h01);
        end
        chk("cnt_saturated", ovf_cnt, 8'hFF);

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule : tb_alu_cmd_ctrl
